comparator_serial_nbit: RTL

- Bit-serial N-bit magnitude comparator built around the existing single-bit `comparator_1bit` cell.
- Accepts two WIDTH-bit operands through a valid/ready handshake and walks them MSB-first, one bit per clock.
- Stops at the first differing bit and returns a one-hot EQ/GT/LT result through a second valid/ready handshake.
- Sits directly downstream of `comparator_1bit`: it consumes that cell's per-bit outputs and extends it to multi-bit operands.

---
 rtl/comparator_pkg.sv | 23 ++
 rtl/comparator_1bit.sv | 14 +
 rtl/comparator_serial_nbit.sv | 95 +++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// rtl/comparator_pkg.sv - shared types and sizing helpers for the serial magnitude comparator
package comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_result_t;

    // Counter and bits_used share one width so both can hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/comparator_1bit.sv
// rtl/comparator_1bit.sv - single-bit magnitude comparator cell
module comparator_1bit (
    input  logic a_i,
    input  logic b_i,
    output logic eq_o,
    output logic gt_o,
    output logic lt_o
);

    assign eq_o = ~(a_i ^ b_i);
    assign gt_o = a_i & ~b_i;
    assign lt_o = ~a_i & b_i;

endmodule

// File: rtl/comparator_serial_nbit.sv
// rtl/comparator_serial_nbit.sv - bit-serial MSB-first N-bit magnitude comparator with valid/ready handshakes
module comparator_serial_nbit
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      A,
    input  logic [WIDTH-1:0]                      B,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  A_eq_B,
    output logic                                  A_gt_B,
    output logic                                  A_lt_B,
    output logic [comparator_pkg::cnt_width(WIDTH)-1:0] bits_used
);

    localparam int CW = cnt_width(WIDTH);

    cmp_state_t        state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     bits_q;
    cmp_result_t       res_q;

    logic bit_eq;
    logic bit_gt;
    logic bit_lt;

    comparator_1bit u_bit (
        .a_i  (a_q[WIDTH-1]),
        .b_i  (b_q[WIDTH-1]),
        .eq_o (bit_eq),
        .gt_o (bit_gt),
        .lt_o (bit_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        cnt_q   <= CW'(WIDTH - 1);
                        bits_q  <= '0;
                        res_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    // First differing bit decides; counter holds the bits still unexamined.
                    if (bit_gt || bit_lt) begin
                        res_q   <= '{eq: 1'b0, gt: bit_gt, lt: bit_lt};
                        bits_q  <= CW'(WIDTH) - cnt_q;
                        state_q <= DONE;
                    end else if (bit_eq && cnt_q == '0) begin
                        res_q   <= '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
                        bits_q  <= CW'(WIDTH);
                        state_q <= DONE;
                    end else begin
                        a_q   <= a_q << 1;
                        b_q   <= b_q << 1;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign A_eq_B    = res_q.eq;
    assign A_gt_B    = res_q.gt;
    assign A_lt_B    = res_q.lt;
    assign bits_used = bits_q;

endmodule
